mitchell_mul_arbiter: RTL and testbench
=======================================

Name: mitchell_mul_arbiter

Overview:
Shares one mul16_Mitchell approximate multiplier among NUM_REQ requesters using round-robin arbitration and a valid/ready handshake.
The block holds the accepted operands in registers, sequences them through the combinational multiplier, and registers the product.
It returns each result with the requester ID.
It sits between the HETM processing lanes and the single shared Mitchell datapath.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
ID_W, $clog2(NUM_REQ), width of the requester ID; derived, not overridden.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; at most one bit high
req_a  in  16*NUM_REQ  flattened operand A; requester i uses bits [16i+15:16i]
req_b  in  16*NUM_REQ  flattened operand B, same packing as req_a
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_id  out  ID_W  index of the requester that owns rsp_c
rsp_c  out  32  Mitchell product of the accepted operands
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=0, op_a=0, op_b=0, rsp_c=0, rsp_id=0, rsp_valid=0; busy=0 and req_ready=0 combinationally.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - grant g = first i with req_valid[i]=1, searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - req_ready[g]=1 combinationally in the same cycle; no bit is high if req_valid=0.
  - On the accept edge: op_a<=req_a[g], op_b<=req_b[g], id<=g, rr_ptr<=(g+1) mod NUM_REQ, state<=CALC.
- CALC: one cycle. The multiplier is driven from op_a/op_b. At the clock edge: rsp_c<=product, rsp_id<=id, rsp_valid<=1, state<=RESP.
- RESP:
  - rsp_valid, rsp_c and rsp_id are held stable until rsp_ready=1.
  - On that edge: rsp_valid<=0, state<=IDLE.
- req_ready is 0 in CALC and RESP; no request is accepted while a result is pending.
- Latency: accept edge at cycle T gives rsp_valid=1 during cycle T+2. With rsp_ready held at 1, the next accept occurs at T+3 at the earliest (1 op per 3 cycles).
- Requesters hold req_valid and operands stable until granted. Deasserting req_valid before grant is legal; that requester is skipped.
- rr_ptr advances only on a grant, so a requester that has just been served has lowest priority on the next arbitration.
- rsp_c carries the full 32-bit output of mul16_Mitchell; no truncation or rounding.
- Reset mid-operation: any pending operand or result is discarded; there is no response for that request.
- rsp_ready while rsp_valid=0 is ignored.

Optional Feature:
MITCHELL_ARB_ZERO_SKIP_EN.
- Defined: in IDLE, if the granted req_a or req_b equals 0, the block skips CALC. It loads rsp_c<=0, rsp_id<=g, rsp_valid<=1 and goes directly to RESP, so rsp_valid=1 at T+1. Arbitration and rr_ptr update are unchanged.
- Undefined: zero operands follow the normal IDLE->CALC->RESP path, and rsp_c equals mul16_Mitchell's output for those operands.

Test Plan:
1. Reset, then req_valid=4'b0001, a0=3, b0=5 -> req_ready=4'b0001 at T; rsp_valid=1 at T+2 with rsp_c=14 and rsp_id=0.
2. Requester 2 with a2=100, b2=200, rsp_ready held 0 for 5 cycles -> rsp_c=18432 and rsp_id=2 held stable all 5 cycles; IDLE one cycle after rsp_ready=1.
3. All four requesters valid continuously with a=16, b=256 and rsp_ready=1 -> grant order 0,1,2,3,0, one grant every 3 cycles, every rsp_c=4096.
4. rst pulsed during CALC for requester 1 -> rsp_valid stays 0, state IDLE, rr_ptr=0; the next grant goes to requester 0 if it is valid.
5. a1=0, b1=1234: with MITCHELL_ARB_ZERO_SKIP_EN defined -> rsp_valid at T+1 with rsp_c=0; without it -> rsp_valid at T+2 with rsp_c equal to the multiplier model output.
6. req_valid=4'b1010 after a grant to requester 3 -> next grant to requester 1; req_ready is never multi-hot over the whole run (assertion).

Source files
------------

// File: rtl/mitchell_mul_arbiter.sv
// mitchell_mul_arbiter: round-robin arbiter that shares one Mitchell
// log-domain approximate 16x16 multiplier among NUM_REQ requesters.
// Operands are captured on grant and held in registers. The product is
// computed during CALC and then held in RESP until the consumer takes it.
// Optional build macro: MITCHELL_ARB_ZERO_SKIP_EN. When it is defined, a
// grant with a zero operand bypasses CALC and returns 0 one cycle early.
module mitchell_mul_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [16*NUM_REQ-1:0]   req_a,
   input  logic [16*NUM_REQ-1:0]   req_b,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [31:0]             rsp_c,
   output logic                    busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t          state_q;
   logic [ID_W-1:0] rr_ptr_q;
   logic [ID_W-1:0] id_q;
   logic [15:0]     op_a_q;
   logic [15:0]     op_b_q;
   logic [31:0]     rsp_c_q;
   logic [ID_W-1:0] rsp_id_q;
   logic            rsp_valid_q;

   logic [15:0]     a_arr [NUM_REQ];
   logic [15:0]     b_arr [NUM_REQ];
   logic            grant_vld;
   logic [ID_W-1:0] grant_id;
   logic [ID_W-1:0] rr_ptr_d;
   logic [15:0]     grant_a;
   logic [15:0]     grant_b;
   logic [31:0]     product;

   // Split the flattened operand buses into one word per requester
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign a_arr[gi] = req_a[16*gi +: 16];
         assign b_arr[gi] = req_b[16*gi +: 16];
      end
   endgenerate

   // Round-robin search starting at rr_ptr. Walking the offsets from the
   // largest to the smallest lets the nearest valid requester win.
   always_comb begin
      int idx;
      grant_vld = 1'b0;
      grant_id  = '0;
      idx       = 0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         idx = int'(rr_ptr_q) + j;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (req_valid[idx]) begin
            grant_vld = 1'b1;
            grant_id  = idx[ID_W-1:0];
         end
      end
   end

   assign grant_a  = a_arr[grant_id];
   assign grant_b  = b_arr[grant_id];
   assign rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

   // The accept strobe exists only in IDLE and is one-hot on the winner
   always_comb begin
      req_ready = '0;
      if (state_q == S_IDLE && grant_vld) begin
         req_ready[grant_id] = 1'b1;
      end
   end

   // Position of the leading one; callers screen out zero inputs
   function automatic logic [3:0] lead_one(input logic [15:0] v);
      lead_one = '0;
      for (int i = 0; i < 16; i++) begin
         if (v[i]) begin
            lead_one = 4'(i);
         end
      end
   endfunction

   // Mitchell product: add the characteristics and the fractional
   // mantissas, then take the antilog with one shift. The fractions are
   // 15-bit fixed point, so the final >>15 is exact.
   always_comb begin
      logic [3:0]  k_a;
      logic [3:0]  k_b;
      logic [15:0] sh_a;
      logic [15:0] sh_b;
      logic [15:0] fsum;
      logic [15:0] mant;
      logic [5:0]  shamt;
      logic [47:0] wide;
      k_a   = lead_one(op_a_q);
      k_b   = lead_one(op_b_q);
      sh_a  = op_a_q << (4'd15 - k_a);
      sh_b  = op_b_q << (4'd15 - k_b);
      // Drop the leading one that now sits at bit 15
      fsum  = {1'b0, 15'(sh_a)} + {1'b0, 15'(sh_b)};
      // Without a fractional carry the mantissa is 1+x1+x2. With a carry,
      // it is x1+x2 and the exponent goes up by one.
      mant  = fsum[15] ? fsum : {1'b1, fsum[14:0]};
      shamt = {2'b00, k_a} + {2'b00, k_b} + {5'd0, fsum[15]};
      wide  = {32'd0, mant} << shamt;
      if (op_a_q == 16'd0 || op_b_q == 16'd0) begin
         product = 32'd0;
      end else begin
         product = 32'(wide >> 15);
      end
   end

   // Control FSM: grant and capture, compute, then hold the result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '0;
         id_q        <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         rsp_c_q     <= '0;
         rsp_id_q    <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (grant_vld) begin
                  op_a_q   <= grant_a;
                  op_b_q   <= grant_b;
                  id_q     <= grant_id;
                  rr_ptr_q <= rr_ptr_d;
`ifdef MITCHELL_ARB_ZERO_SKIP_EN
                  if (grant_a == 16'd0 || grant_b == 16'd0) begin
                     rsp_c_q     <= 32'd0;
                     rsp_id_q    <= grant_id;
                     rsp_valid_q <= 1'b1;
                     state_q     <= S_RESP;
                  end else begin
                     state_q <= S_CALC;
                  end
`else
                  state_q  <= S_CALC;
`endif
               end
            end
            S_CALC: begin
               rsp_c_q     <= product;
               rsp_id_q    <= id_q;
               rsp_valid_q <= 1'b1;
               state_q     <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_c     = rsp_c_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mitchell_mul_arbiter.sv
// Testbench for mitchell_mul_arbiter (NUM_REQ=4). It runs a table of
// single-requester vectors, hand sequences for the multi-cycle corners,
// and randomized transactions. Results are compared against an arithmetic
// Mitchell model and a round-robin pointer model.
module tb_mitchell_mul_arbiter;
   localparam int N    = 4;
   localparam int ID_W = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [N-1:0]      req_valid = '0;
   logic [N-1:0]      req_ready;
   logic [16*N-1:0]   req_a = '0;
   logic [16*N-1:0]   req_b = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [ID_W-1:0]   rsp_id;
   logic [31:0]       rsp_c;
   logic              busy;

   int n_vec = 0;
   int n_mis = 0;
   int rr_model = 0;
   logic [15:0] op_a [N];
   logic [15:0] op_b [N];

   mitchell_mul_arbiter #(.NUM_REQ(N)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_c(rsp_c), .busy(busy)
   );

   always #5 clk = ~clk;

   // req_ready must never be multi-hot
   always @(negedge clk) begin
      n_vec++;
      if (!$onehot0(req_ready)) begin
         n_mis++;
         $display("FAIL onehot_ready: req_ready=%b is multi-hot", req_ready);
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Mitchell approximation in plain integers. With a = 2^k1 + r1 and
   // b = 2^k2 + r2, the approximation is a*2^k2 + b*2^k1 - 2^(k1+k2) when
   // r1*2^k2 + r2*2^k1 < 2^(k1+k2). Otherwise it is twice that sum.
   function automatic longint mref(input longint a, input longint b);
      longint k1, k2, r1, r2, s;
      if (a == 0 || b == 0) return 0;
      k1 = $clog2(a + 1) - 1;
      k2 = $clog2(b + 1) - 1;
      r1 = a - (64'sd1 << k1);
      r2 = b - (64'sd1 << k2);
      s  = r1 * (64'sd1 << k2) + r2 * (64'sd1 << k1);
      if (s < (64'sd1 << (k1 + k2)))
         return a * (64'sd1 << k2) + b * (64'sd1 << k1) - (64'sd1 << (k1 + k2));
      else
         return 2 * s;
   endfunction

   function automatic int model_grant(input logic [N-1:0] mask);
      for (int j = 0; j < N; j++) begin
         if (mask[(rr_model + j) % N]) return (rr_model + j) % N;
      end
      return -1;
   endfunction

   task automatic pack_ops();
      for (int i = 0; i < N; i++) begin
         req_a[16*i +: 16] = op_a[i];
         req_b[16*i +: 16] = op_b[i];
      end
   endtask

   // Reset and check the reset state. The task ends just after a negedge.
   task automatic do_reset();
      req_valid = '0;
      rsp_ready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_c", rsp_c, 0);
      chk("rst_rsp_id", rsp_id, 0);
      rst = 1'b0;
      rr_model = 0;
      @(negedge clk);
   endtask

   // One full transaction. The caller sets op_a/op_b first. The task is
   // entered and left just after a negedge with the DUT in IDLE.
   task automatic txn(input logic [N-1:0] mask, input longint exp_c, input int stall);
      int g, lat, cyc;
      bit got;
      g = model_grant(mask);
      pack_ops();
      req_valid = mask;
      rsp_ready = (stall == 0);
      #1;
      chk("grant", req_ready, longint'(1) << g);
      lat = 2;
`ifdef MITCHELL_ARB_ZERO_SKIP_EN
      if (op_a[g] == 16'd0 || op_b[g] == 16'd0) lat = 1;
`endif
      @(posedge clk);
      #1 req_valid = '0;
      rr_model = (g + 1) % N;
      got = 1'b0;
      for (cyc = 1; cyc <= 6; cyc++) begin
         @(negedge clk);
         if (rsp_valid) begin
            got = 1'b1;
            break;
         end
      end
      chk("rsp_latency", got ? cyc : -1, lat);
      if (!got) begin
         do_reset();
         return;
      end
      chk("rsp_c", rsp_c, exp_c);
      chk("rsp_id", rsp_id, g);
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         chk("hold_valid", rsp_valid, 1);
         chk("hold_c", rsp_c, exp_c);
         chk("hold_id", rsp_id, g);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_rsp_valid", rsp_valid, 0);
   endtask

   typedef struct {
      int          idx;
      logic [15:0] a;
      logic [15:0] b;
      longint      exp_c;
      int          stall;
   } vec_t;

   vec_t tbl [8];

   initial begin
      int ngr, last, gidx;
      logic [N-1:0] mask;

      tbl[0] = '{0, 16'd3,     16'd5,     64'd14,         0};
      tbl[1] = '{2, 16'd100,   16'd200,   64'd18432,      5};
      tbl[2] = '{1, 16'd16,    16'd256,   64'd4096,       0};
      tbl[3] = '{3, 16'd65535, 16'd65535, 64'd4294836224, 1};
      tbl[4] = '{1, 16'd1,     16'd1,     64'd1,          0};
      tbl[5] = '{0, 16'd256,   16'd256,   64'd65536,      2};
      tbl[6] = '{2, 16'd7,     16'd7,     64'd48,         0};
      tbl[7] = '{3, 16'd1000,  16'd3,     64'd2976,       3};

      do_reset();

      // Table vectors. Unselected requesters carry random operands.
      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < N; i++) begin
            op_a[i] = 16'($urandom);
            op_b[i] = 16'($urandom);
         end
         op_a[tbl[t].idx] = tbl[t].a;
         op_b[tbl[t].idx] = tbl[t].b;
         txn(N'(1) << tbl[t].idx, tbl[t].exp_c, tbl[t].stall);
      end

      // All requesters valid back-to-back: order 0,1,2,3,0 every 3 cycles
      do_reset();
      for (int i = 0; i < N; i++) begin
         op_a[i] = 16'd16;
         op_b[i] = 16'd256;
      end
      pack_ops();
      rsp_ready = 1'b1;
      req_valid = '1;
      ngr = 0;
      last = 0;
      for (int cyc = 0; cyc < 30 && ngr < 5; cyc++) begin
         #1;
         if (rsp_valid) chk("rr_rsp_c", rsp_c, 4096);
         if (req_ready != '0) begin
            gidx = -1;
            for (int i = 0; i < N; i++) if (req_ready[i]) gidx = i;
            chk("rr_order", gidx, ngr % N);
            if (ngr > 0) chk("rr_interval", cyc - last, 3);
            last = cyc;
            ngr++;
            if (ngr == 5) begin
               @(posedge clk);
               #1 req_valid = '0;
            end
         end
         @(negedge clk);
      end
      chk("rr_grant_count", ngr, 5);
      repeat (4) @(negedge clk);
      chk("rr_idle_busy", busy, 0);
      rr_model = 1;

      // Reset during CALC drops the request and returns rr_ptr to 0
      do_reset();
      op_a[1] = 16'd9;
      op_b[1] = 16'd11;
      pack_ops();
      req_valid = 4'b0010;
      #1 chk("mid_grant", req_ready, 4'b0010);
      @(posedge clk);
      #1 req_valid = '0;
      #1 rst = 1'b1;
      #2 rst = 1'b0;
      rr_model = 0;
      @(negedge clk);
      chk("mid_rsp_valid", rsp_valid, 0);
      chk("mid_busy", busy, 0);
      @(negedge clk);
      chk("mid_rsp_valid2", rsp_valid, 0);
      op_a[0] = 16'd12;
      op_b[0] = 16'd12;
      txn(4'b0011, mref(12, 12), 0);

      // A zero operand skips CALC only when the feature is built in
      op_a[1] = 16'd0;
      op_b[1] = 16'd1234;
      txn(4'b0010, 0, 1);

      // Serve requester 3, then 1010 must grant requester 1
      op_a[3] = 16'd321;
      op_b[3] = 16'd45;
      txn(4'b1000, mref(321, 45), 0);
      op_a[1] = 16'd77;
      op_b[1] = 16'd88;
      txn(4'b1010, mref(77, 88), 0);

      // Randomized transactions against the reference models
      for (int t = 0; t < 150; t++) begin
         for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 7))
               0:       op_a[i] = 16'd0;
               1, 2:    op_a[i] = 16'($urandom_range(1, 255));
               default: op_a[i] = 16'($urandom);
            endcase
            case ($urandom_range(0, 7))
               0:       op_b[i] = 16'd0;
               1, 2:    op_b[i] = 16'($urandom_range(1, 255));
               default: op_b[i] = 16'($urandom);
            endcase
         end
         mask = N'($urandom_range(1, (1 << N) - 1));
         gidx = model_grant(mask);
         txn(mask, mref(op_a[gidx], op_b[gidx]), $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

   // Global time limit
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, limit %0d reached", 500000);
      $fatal(1);
   end
endmodule
